// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control for a synchronous instruction ROM with one cycle of read latency.
// Keeps if_pc/if_valid aligned with the ROM output word, and handles stalls, redirects and address wrap.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 12,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             zero_n,
  input  logic             stall_in,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      pc_out,
  output logic             freeze,
  output logic [31:0]      if_pc,
  output logic             if_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

  localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * (IMEM_WORDS - 1));

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic             if_valid_q, if_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Sequential successor; only the last word of the fetch space wraps.
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return (a == LAST_PC) ? RESET_PC : a + 32'd4;
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      // The word the ROM latches at this edge is wrong-path, so it is squashed.
      pc_d       = {redirect_target[31:2], 2'b00};
      if_pc_d    = pc_q;
      if_valid_d = 1'b0;
      state_d    = FLUSH;
      if (redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (stall_in) begin
      state_d = STALL;
    end else begin
      pc_d       = next_pc(pc_q);
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      state_d    = RUN;
    end
    cnt_d = if_valid_d ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge zero_n) begin
    if (!zero_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out       = pc_q;
  assign freeze       = stall_in & ~redirect_valid;
  assign if_pc        = if_pc_q;
  assign if_valid     = if_valid_q;
  assign misalign_err = misalign_q;
  assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver queues hand-computed post-edge state,
// and a monitor compares it against the DUT one step after each rising edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        zero_n;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;
  logic        freeze;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic        vld;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(12), .CNT_W(32)) dut (
    .clk             (clk),
    .zero_n          (zero_n),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_out          (pc_out),
    .freeze          (freeze),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .misalign_err    (misalign_err),
    .fetch_cnt       (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every post-edge sample with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".pc_out"},   pc_out,               e.pc);
        chk({e.tag, ".if_pc"},    if_pc,                e.ifpc);
        chk({e.tag, ".if_valid"}, {31'b0, if_valid},    {31'b0, e.vld});
        chk({e.tag, ".misalign"}, {31'b0, misalign_err}, {31'b0, e.err});
        chk({e.tag, ".fetch_cnt"}, fetch_cnt,           e.cnt);
      end
    end
  end

  // Drive one cycle of inputs, check freeze, queue the expected state after the edge.
  task automatic step(input string tag, input logic st, input logic rv, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_ifpc, input logic e_vld,
                      input logic e_err, input logic [31:0] e_cnt);
    exp_t e;
    stall_in        = st;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    chk({tag, ".freeze"}, {31'b0, freeze}, {31'b0, st & ~rv});
    e.tag = tag; e.pc = e_pc; e.ifpc = e_ifpc; e.vld = e_vld; e.err = e_err; e.cnt = e_cnt;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc_out"},    pc_out,               32'h0);
    chk({tag, ".if_pc"},     if_pc,                32'h0);
    chk({tag, ".if_valid"},  {31'b0, if_valid},    32'h0);
    chk({tag, ".misalign"},  {31'b0, misalign_err}, 32'h0);
    chk({tag, ".fetch_cnt"}, fetch_cnt,            32'h0);
  endtask

  initial begin
    zero_n          = 1'b0;
    stall_in        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'hFFFF_FFFF;
    #2;
    chk_reset("reset");
    #10 zero_n = 1'b1;

    // Boot and sequential run up to the wrap point.
    for (int k = 1; k <= 11; k++)
      step("seq", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'(4 * k), 32'(4 * (k - 1)), 1'b1, 1'b0, 32'(k));
    step("wrap0", 1'b0, 1'b0, 32'h0, 32'h00, 32'h2C, 1'b1, 1'b0, 32'd12);
    step("wrap1", 1'b0, 1'b0, 32'h0, 32'h04, 32'h00, 1'b1, 1'b0, 32'd13);
    step("seq14", 1'b0, 1'b0, 32'h0, 32'h08, 32'h04, 1'b1, 1'b0, 32'd14);
    step("seq15", 1'b0, 1'b0, 32'h0, 32'h0C, 32'h08, 1'b1, 1'b0, 32'd15);
    step("seq16", 1'b0, 1'b0, 32'h0, 32'h10, 32'h0C, 1'b1, 1'b0, 32'd16);

    // Stall for three cycles: fetch state holds, if_valid stays 1 so cycles still count.
    step("stall1", 1'b1, 1'b0, 32'h0, 32'h10, 32'h0C, 1'b1, 1'b0, 32'd17);
    step("stall2", 1'b1, 1'b0, 32'h0, 32'h10, 32'h0C, 1'b1, 1'b0, 32'd18);
    step("stall3", 1'b1, 1'b0, 32'h0, 32'h10, 32'h0C, 1'b1, 1'b0, 32'd19);
    step("unstall", 1'b0, 1'b0, 32'h0, 32'h14, 32'h10, 1'b1, 1'b0, 32'd20);

    // Redirect to 0x08, then re-target to 0x20 while still in the bubble.
    step("redir08", 1'b0, 1'b1, 32'h08, 32'h08, 32'h14, 1'b0, 1'b0, 32'd20);
    step("redir20", 1'b0, 1'b1, 32'h20, 32'h20, 32'h08, 1'b0, 1'b0, 32'd20);
    step("tgt20",   1'b0, 1'b0, 32'h0,  32'h24, 32'h20, 1'b1, 1'b0, 32'd21);
    step("seq24",   1'b0, 1'b0, 32'h0,  32'h28, 32'h24, 1'b1, 1'b0, 32'd22);

    // Stall and redirect together: redirect wins, freeze is low.
    step("both",  1'b1, 1'b1, 32'h04, 32'h04, 32'h28, 1'b0, 1'b0, 32'd22);
    step("tgt04", 1'b0, 1'b0, 32'h0,  32'h08, 32'h04, 1'b1, 1'b0, 32'd23);

    // Misaligned target sets the sticky error, which survives an aligned redirect.
    step("mis13",  1'b0, 1'b1, 32'h13, 32'h10, 32'h08, 1'b0, 1'b1, 32'd23);
    step("redir2c", 1'b0, 1'b1, 32'h2C, 32'h2C, 32'h10, 1'b0, 1'b1, 32'd23);
    step("tgt2c",  1'b0, 1'b0, 32'h0,  32'h00, 32'h2C, 1'b1, 1'b1, 32'd24);

    // Out-of-range target passes through and does not wrap.
    step("oor",    1'b0, 1'b1, 32'h100, 32'h100, 32'h00, 1'b0, 1'b1, 32'd24);
    step("oor+4",  1'b0, 1'b0, 32'h0,   32'h104, 32'h100, 1'b1, 1'b1, 32'd25);
    step("stallx", 1'b1, 1'b0, 32'h0,   32'h104, 32'h100, 1'b1, 1'b1, 32'd26);

    // Asynchronous reset mid-stall clears everything at once.
    zero_n = 1'b0;
    #1;
    chk_reset("midreset");
    stall_in = 1'b0;
    #1 zero_n = 1'b1;
    step("reboot", 1'b0, 1'b0, 32'h0, 32'h04, 32'h00, 1'b1, 1'b0, 32'd1);

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
